uart_mem_bridge: RTL and testbench

Byte-level command responder behind the UART pair: it takes received bytes from the UART receiver, decodes host read/write commands, runs one 32-bit transaction on a simple request/acknowledge memory port, and returns the response bytes through the UART transmitter's valid/ready input. It is the target end of the host debug link, sitting between the UART blocks and the system memory/peripheral bus.

---
 rtl/uart_mem_bridge.sv | 181 ++++++++++++++++++
 tb/tb_uart_mem_bridge.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_bridge.sv
// Byte-level command responder: decodes 'W'/'R' host frames from the UART receiver,
// runs one 32-bit request/acknowledge bus transaction and streams the reply to the transmitter.
module uart_mem_bridge #(
  parameter int TIMEOUT_CYCLES = 1 << 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err_overrun,
  output logic        err_timeout
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] CMD_W   = 8'h57;
  localparam logic [7:0] CMD_R   = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

  state_t             r_state;
  logic [1:0]         r_cnt;
  logic [1:0]         r_left;
  logic [31:0]        r_rdata;
  logic [TMO_W-1:0]   r_tmo;
  logic               r_tx_valid;
  logic [7:0]         r_tx_data;
  logic               r_mem_req;
  logic               r_mem_we;
  logic [31:0]        r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic               r_err_overrun;
  logic               r_err_timeout;

  logic               w_collecting;
  logic               w_tmo_hit;

  assign w_collecting = (r_state == S_ADDR) || (r_state == S_DATA);
  assign w_tmo_hit    = (r_tmo == TMO_W'(TIMEOUT_CYCLES));

  assign tx_valid    = r_tx_valid;
  assign tx_data     = r_tx_data;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign err_overrun = r_err_overrun;
  assign err_timeout = r_err_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_left        <= '0;
      r_rdata       <= '0;
      r_tmo         <= '0;
      r_tx_valid    <= 1'b0;
      r_tx_data     <= 8'h00;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_err_overrun <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      // An arriving byte always beats a simultaneous timeout expiry.
      if (rx_valid || !w_collecting) begin
        r_tmo <= '0;
      end else if (!w_tmo_hit) begin
        r_tmo <= r_tmo + TMO_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (rx_valid) begin
            if (rx_data == CMD_W || rx_data == CMD_R) begin
              r_mem_we <= (rx_data == CMD_W);
              r_cnt    <= '0;
              r_state  <= S_ADDR;
            end else begin
              r_tx_data  <= RSP_ERR;
              r_tx_valid <= 1'b1;
              r_left     <= '0;
              r_state    <= S_RESP;
            end
          end
        end

        S_ADDR: begin
          if (rx_valid) begin
            r_mem_addr <= {r_mem_addr[23:0], rx_data};
            r_cnt      <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              if (r_mem_we) begin
                r_state <= S_DATA;
              end else begin
                r_state   <= S_BUS;
                r_mem_req <= 1'b1;
              end
            end
          end else if (w_tmo_hit) begin
            r_state       <= S_IDLE;
            r_err_timeout <= 1'b1;
          end
        end

        S_DATA: begin
          if (rx_valid) begin
            r_mem_wdata <= {r_mem_wdata[23:0], rx_data};
            r_cnt       <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state   <= S_BUS;
              r_mem_req <= 1'b1;
            end
          end else if (w_tmo_hit) begin
            r_state       <= S_IDLE;
            r_err_timeout <= 1'b1;
          end
        end

        S_BUS: begin
          if (rx_valid) begin
            r_err_overrun <= 1'b1;
          end
          if (mem_ack) begin
            r_mem_req  <= 1'b0;
            r_tx_valid <= 1'b1;
            r_state    <= S_RESP;
            if (r_mem_we) begin
              r_tx_data <= RSP_OK;
              r_left    <= '0;
            end else begin
              r_rdata   <= mem_rdata;
              r_tx_data <= mem_rdata[31:24];
              r_left    <= 2'd3;
            end
          end
        end

        S_RESP: begin
          if (rx_valid) begin
            r_err_overrun <= 1'b1;
          end
          // r_rdata is shifted so its [23:16] always holds the next byte to offer.
          if (r_tx_valid && tx_ready) begin
            if (r_left == 2'd0) begin
              r_tx_valid <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_tx_data <= r_rdata[23:16];
              r_rdata   <= {r_rdata[23:0], 8'h00};
              r_left    <= r_left - 2'd1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Scoreboard bench for uart_mem_bridge: a frame-level model queues expected bus
// transactions and reply bytes; a bus responder and a tx monitor pop and compare.
module tb_uart_mem_bridge;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        err_overrun;
  logic        err_timeout;

  uart_mem_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
  } bus_t;

  bus_t       bus_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] frame[$];
  int         tests = 0;
  int         fails = 0;
  logic       hold_ack = 1'b0;
  logic       stall_tx = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: builds the frame and queues what the bridge must do with it.
  // kind 0 = write, 1 = read, 2 = unknown command byte (taken from addr[7:0]).
  task automatic model_cmd(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int dly);
    bus_t b;
    frame.delete();
    b.we = (kind == 0); b.addr = addr; b.wdata = wdata; b.rdata = rdata; b.dly = dly;
    if (kind == 2) begin
      frame.push_back(addr[7:0]);
      exp_q.push_back(8'h3F);
    end else begin
      frame.push_back(kind == 0 ? 8'h57 : 8'h52);
      for (int i = 3; i >= 0; i--) frame.push_back(8'((addr >> (8 * i)) & 32'hFF));
      if (kind == 0) begin
        for (int i = 3; i >= 0; i--) frame.push_back(8'((wdata >> (8 * i)) & 32'hFF));
        exp_q.push_back(8'h4B);
      end else begin
        for (int i = 3; i >= 0; i--) exp_q.push_back(8'((rdata >> (8 * i)) & 32'hFF));
      end
      bus_q.push_back(b);
    end
  endtask

  task automatic send_frame(input int kind, input int gap);
    for (int i = 0; i < frame.size(); i++) begin
      rx_valid = 1'b1;
      rx_data  = frame[i];
      tick();
      rx_valid = 1'b0;
      if (i == frame.size() - 1) begin
        if (kind == 2) chk("tx_rise_invalid", tx_valid, 1'b1);
        else           chk("req_rise", mem_req, 1'b1);
      end else begin
        repeat (gap < 0 ? $urandom_range(0, 3) : gap) tick();
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || bus_q.size() != 0 || tx_valid || mem_req) && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) fail_now("wait_idle");
  endtask

  task automatic do_cmd(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int dly, input int gap);
    model_cmd(kind, addr, wdata, rdata, dly);
    send_frame(kind, gap);
    wait_idle();
  endtask

  initial begin
    tx_ready = 1'b0;
    forever begin
      tick();
      tx_ready = stall_tx ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // Bus responder: checks each request against the model and acknowledges it.
  initial begin
    bus_t b;
    int   d;
    logic gone;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      tick();
      mem_ack = 1'b0;
      if (rst) continue;
      if (mem_req) begin
        if (bus_q.size() == 0) begin
          fail_now("unexpected_req");
          mem_ack = 1'b1;
          tick();
          mem_ack = 1'b0;
          continue;
        end
        b = bus_q.pop_front();
        chk("mem_we", mem_we, b.we);
        chk("mem_addr", mem_addr, b.addr);
        if (b.we) chk("mem_wdata", mem_wdata, b.wdata);
        d = b.dly;
        gone = 1'b0;
        while (hold_ack || d > 0) begin
          tick();
          if (!mem_req) begin gone = 1'b1; break; end
          if (!hold_ack) d--;
        end
        if (gone) continue;
        mem_ack   = 1'b1;
        mem_rdata = b.rdata;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        chk("req_fall", mem_req, 1'b0);
        chk("tx_rise", tx_valid, 1'b1);
      end else if ($urandom_range(0, 7) == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
      end
    end
  end

  // Reply monitor and hold checks, sampled away from the active edge.
  logic        pv = 1'b0, pr = 1'b0, preq = 1'b0, pack = 1'b0, pwe = 1'b0;
  logic [7:0]  pd = '0;
  logic [31:0] pa = '0, pw = '0;
  always @(negedge clk) begin
    if (rst) begin
      pv   <= 1'b0;
      preq <= 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("tx_hold_valid", tx_valid, 1'b1);
        chk("tx_hold_data", tx_data, pd);
      end
      if (preq && !pack) begin
        chk("req_hold", mem_req, 1'b1);
        chk("addr_hold", mem_addr, pa);
        chk("we_hold", mem_we, pwe);
        chk("wdata_hold", mem_wdata, pw);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) fail_now("tx_unexpected");
        else chk("tx_byte", tx_data, exp_q.pop_front());
      end
      pv <= tx_valid; pr <= tx_ready; pd <= tx_data;
      preq <= mem_req; pack <= mem_ack; pa <= mem_addr; pw <= mem_wdata; pwe <= mem_we;
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx_valid"}, tx_valid, 1'b0);
    chk({tag, "_tx_data"}, tx_data, 8'h00);
    chk({tag, "_mem_req"}, mem_req, 1'b0);
    chk({tag, "_mem_we"}, mem_we, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_err_overrun"}, err_overrun, 1'b0);
    chk({tag, "_err_timeout"}, err_timeout, 1'b0);
  endtask

  initial begin
    int          kind;
    int          n;
    logic [7:0]  bad;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (3) tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();

    do_cmd(0, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 3, 0);
    do_cmd(1, 32'h8000_0004, 32'h0, 32'h1234_5678, 2, 0);
    do_cmd(2, 32'h41, 32'h0, 32'h0, 0, 0);
    do_cmd(1, 32'hCAFE_0010, 32'h0, 32'hA5A5_0FF0, 0, 0);
    do_cmd(0, 32'h0000_0003, 32'h0102_0304, 32'h0, 1, 12);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 4);
      if (kind > 2) kind = kind - 3;
      bad = 8'($urandom);
      while (bad == 8'h57 || bad == 8'h52) bad = 8'($urandom);
      do_cmd(kind, kind == 2 ? {24'h0, bad} : $urandom, $urandom, $urandom,
             $urandom_range(0, 4), -1);
    end
    chk("no_overrun_yet", err_overrun, 1'b0);
    chk("no_timeout_yet", err_timeout, 1'b0);

    hold_ack = 1'b1;
    model_cmd(0, 32'h0000_2000, 32'h5555_AAAA, 32'h0, 0);
    send_frame(0, 0);
    rx_valid = 1'b1;
    rx_data  = 8'h52;
    tick();
    rx_valid = 1'b0;
    chk("overrun_set", err_overrun, 1'b1);
    hold_ack = 1'b0;
    wait_idle();
    do_cmd(1, 32'h0000_2000, 32'h0, 32'h0BAD_F00D, 1, -1);

    frame.delete();
    frame.push_back(8'h57);
    frame.push_back(8'h01);
    for (int i = 0; i < 2; i++) begin
      rx_valid = 1'b1;
      rx_data  = frame[i];
      tick();
      rx_valid = 1'b0;
    end
    repeat (TMO + 6) tick();
    chk("timeout_set", err_timeout, 1'b1);
    chk("timeout_no_req", mem_req, 1'b0);
    chk("timeout_no_tx", tx_valid, 1'b0);
    do_cmd(1, 32'h0000_0040, 32'h0, 32'h7788_99AA, 0, -1);

    hold_ack = 1'b1;
    model_cmd(0, 32'h0000_3000, 32'h1111_2222, 32'h0, 0);
    send_frame(0, 0);
    repeat (2) tick();
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_bus");
    tick();
    rst = 1'b0;
    exp_q.delete();
    bus_q.delete();
    hold_ack = 1'b0;
    tick();
    do_cmd(0, 32'h0000_3004, 32'h3333_4444, 32'h0, 2, -1);

    stall_tx = 1'b1;
    tx_ready = 1'b0;
    model_cmd(1, 32'h0000_5000, 32'h0, 32'hFEED_FACE, 1);
    send_frame(1, 0);
    n = 0;
    while (!tx_valid && n < 100) begin tick(); n++; end
    if (n >= 100) fail_now("resp_wait");
    repeat (3) tick();
    chk("resp_stalled_data", tx_data, 8'hFE);
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_resp");
    tick();
    rst = 1'b0;
    exp_q.delete();
    bus_q.delete();
    stall_tx = 1'b0;
    tick();
    do_cmd(1, 32'h0000_5000, 32'h0, 32'h0123_4567, 1, -1);

    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
